// File: rtl/tdc_pkg.sv
// Shared types and constants for the TOF result buffer: word layout, FSM states
// and the packing helper.
package tdc_pkg;

  localparam int TOF_W    = 15;
  localparam int IDX_W    = 2;
  localparam int WORD_W   = 18;

  localparam int LAST_BIT = 17;
  localparam int IDX_LSB  = 15;
  localparam int TOF_LSB  = 0;

  localparam logic [TOF_W-1:0] TOF_OOR = 15'h7FFF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    COLLECT
  } state_e;

  function automatic logic [WORD_W-1:0] pack_word(input logic             last,
                                                  input logic [IDX_W-1:0] idx,
                                                  input logic [TOF_W-1:0] tof);
    return {last, idx, tof};
  endfunction

endpackage

// File: rtl/tof_result_buf_if.sv
// Readout handshake of the TOF result buffer: FWFT data with valid/ready.
interface tof_result_buf_if;
  import tdc_pkg::*;

  logic              rd_valid;
  logic              rd_ready;
  logic [WORD_W-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input  rd_ready);
  modport slave  (input  rd_valid, input  rd_data, output rd_ready);

endinterface

// File: rtl/tdc_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy level.
// A write is refused whenever the FIFO is full at the start of the cycle.
module tdc_sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; empty/level gate every read, so contents never leak.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/tof_result_buf.sv
// Frames TOF stop hits (index + last flag) and buffers them for readout.
// Optional macro TOF_RANGE_FILTER_EN drops out-of-range hits from storage.
module tof_result_buf
  import tdc_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int MAX_HITS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tri_en,
  input  logic                   tof_valid,
  input  logic [TOF_W-1:0]       tof_data,
  input  logic                   frame_close,
  tof_result_buf_if.master       rd,
  output logic                   ovf,
  input  logic                   clr_ovf,
  output logic [7:0]             frame_cnt,
  output logic [$clog2(DEPTH):0] level
);

  localparam logic [IDX_W-1:0]  MAX_HITS_C  = IDX_W'(MAX_HITS);
  localparam logic [WORD_W-1:0] NO_HIT_WORD = pack_word(1'b1, '0, TOF_OOR);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              pend_vld_q, pend_vld_d;
  logic [WORD_W-1:0] pend_word_q, pend_word_d;
  logic              flush_q, flush_d;
  logic [IDX_W-1:0]  cnt_next;
  logic              hit_keep;
  logic              store;
  logic              close_now;
  logic              wr_req;
  logic [WORD_W-1:0] wr_word;
  logic              frame_inc;
  logic              fifo_full;
  logic              fifo_empty;

`ifdef TOF_RANGE_FILTER_EN
  assign hit_keep = (tof_data != TOF_OOR);
`else
  assign hit_keep = 1'b1;
`endif

  assign cnt_next  = hit_cnt_q + IDX_W'(tof_valid);
  assign store     = tof_valid & hit_keep;
  assign close_now = (tof_valid && cnt_next == MAX_HITS_C) || frame_close || tri_en;

  // flush_q: pending holds a closing word that could not share the write port
  // with the word ahead of it; it goes out on the following cycle.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    hit_cnt_d   = hit_cnt_q;
    idx_d       = idx_q;
    pend_vld_d  = pend_vld_q;
    pend_word_d = pend_word_q;
    flush_d     = 1'b0;
    wr_req      = 1'b0;
    wr_word     = '0;
    frame_inc   = 1'b0;

    if (flush_q) begin
      wr_req     = 1'b1;
      wr_word    = pend_word_q;
      pend_vld_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (tri_en) state_d = WAIT_START;
      end

      WAIT_START: begin
        if (tri_en) begin
          state_d = WAIT_START;
        end else if (frame_close) begin
          frame_inc = 1'b1;
          state_d   = IDLE;
          if (flush_q) begin
            pend_vld_d  = 1'b1;
            pend_word_d = NO_HIT_WORD;
            flush_d     = 1'b1;
          end else begin
            wr_req  = 1'b1;
            wr_word = NO_HIT_WORD;
          end
        end else if (tof_valid) begin
          state_d   = COLLECT;
          hit_cnt_d = '0;
          idx_d     = '0;
        end
      end

      COLLECT: begin
        if (tof_valid) hit_cnt_d = cnt_next;
        if (store) begin
          idx_d = idx_q + IDX_W'(1);
          if (pend_vld_q) begin
            wr_req  = 1'b1;
            wr_word = pend_word_q;
          end
          if (close_now && !pend_vld_q) begin
            wr_req     = 1'b1;
            wr_word    = pack_word(1'b1, idx_q, tof_data);
            pend_vld_d = 1'b0;
          end else begin
            pend_vld_d  = 1'b1;
            pend_word_d = pack_word(close_now, idx_q, tof_data);
            flush_d     = close_now;
          end
        end else if (close_now) begin
          wr_req     = 1'b1;
          wr_word    = pend_vld_q ? {1'b1, pend_word_q[WORD_W-2:0]} : NO_HIT_WORD;
          pend_vld_d = 1'b0;
        end
        if (close_now) begin
          frame_inc = 1'b1;
          state_d   = tri_en ? WAIT_START : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hit_cnt_q   <= '0;
      idx_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_word_q <= '0;
      flush_q     <= 1'b0;
      ovf         <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      hit_cnt_q   <= hit_cnt_d;
      idx_q       <= idx_d;
      pend_vld_q  <= pend_vld_d;
      pend_word_q <= pend_word_d;
      flush_q     <= flush_d;
      if (clr_ovf)                 ovf <= 1'b0;
      else if (wr_req & fifo_full) ovf <= 1'b1;
      if (frame_inc) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  tdc_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_req),
    .wr_data (wr_word),
    .rd_en   (rd.rd_ready),
    .rd_data (rd.rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign rd.rd_valid = ~fifo_empty;

endmodule
